// File: rtl/hazard_pkg.sv
// Shared sizing defaults and types for the multi-cycle hazard scoreboard.
package hazard_pkg;
   localparam int NREG     = 32;
   localparam int RW       = 5;
   localparam int CW       = 3;
   localparam int LAT_LOAD = 1;

   typedef logic [RW-1:0] reg_idx_t;
   typedef logic [CW-1:0] lat_t;
endpackage

// File: rtl/hazard_busy_cnt.sv
// One per-register countdown: loads remaining stall cycles, decrements to zero.
module hazard_busy_cnt #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt,
   output logic          busy
);
   localparam logic [CW-1:0] ONE = CW'(1);

   // A new producer always overrides an in-progress countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               cnt <= '0;
      else if (load)         cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - ONE;
   end

   assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: per-register latency countdowns drive IF/ID stall and flush.
// Optional HAZARD_STALL_STATS_EN adds a saturating stall_count output.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG = hazard_pkg::NREG,
   parameter int RW   = hazard_pkg::RW,
   parameter int CW   = hazard_pkg::CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] if_id_rs,
   input  logic [RW-1:0] if_id_rt,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic          ex_issue_valid,
   input  logic [RW-1:0] ex_issue_rd,
   input  logic [CW-1:0] ex_issue_lat,
   input  logic          pridictor_wrong,
   output logic          if_id_pc_write,
   output logic          if_id_write_from_hazard_detector,
`ifdef HAZARD_STALL_STATS_EN
   output logic [31:0]   stall_count,
`endif
   output logic          id_mux_load_use
);
   localparam logic [CW-1:0] LAT_ONE = CW'(LAT_LOAD);

   logic [NREG-1:0]         busy;
   logic [NREG-1:0][CW-1:0] cnt;
   logic                    issue_live;
   logic                    pend_rs, pend_rt, haz;

   assign issue_live = ex_issue_valid && (ex_issue_rd != '0) && (ex_issue_lat != '0);

   assign busy[0] = 1'b0;
   assign cnt[0]  = '0;

   for (genvar g = 1; g < NREG; g++) begin : g_cnt
      hazard_busy_cnt #(.CW(CW)) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .load     (issue_live && (ex_issue_rd == RW'(g))),
         .load_val (ex_issue_lat - LAT_ONE),
         .cnt      (cnt[g]),
         .busy     (busy[g])
      );
   end

   // The EX instruction itself counts as pending so a back-to-back consumer stalls.
   assign pend_rs = (issue_live && (ex_issue_rd == if_id_rs)) || busy[if_id_rs];
   assign pend_rt = (issue_live && (ex_issue_rd == if_id_rt)) || busy[if_id_rt];
   assign haz     = (id_uses_rs && pend_rs) || (id_uses_rt && pend_rt);

   assign if_id_pc_write                   = !(haz && !pridictor_wrong);
   assign if_id_write_from_hazard_detector = !(haz || pridictor_wrong);
   assign id_mux_load_use                  = !(haz || pridictor_wrong);

`ifdef HAZARD_STALL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_count <= '0;
      else if (haz && !pridictor_wrong && (stall_count != 32'hFFFF_FFFF))
         stall_count <= stall_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + randomized bench for hazard_scoreboard against a remaining-cycles model.
module tb_hazard_scoreboard;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] if_id_rs = '0, if_id_rt = '0, ex_issue_rd = '0;
   logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_issue_valid = 1'b0;
   logic [2:0] ex_issue_lat = '0;
   logic       pridictor_wrong = 1'b0;
   logic       if_id_pc_write, if_id_write_from_hazard_detector, id_mux_load_use;
`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] stall_count;
   longint      m_stats = 0;
`endif

   int checks = 0;
   int errors = 0;
   int m_rem [32];
   logic last_pc, last_w, last_m;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk                              (clk),
      .rst                              (rst),
      .if_id_rs                         (if_id_rs),
      .if_id_rt                         (if_id_rt),
      .id_uses_rs                       (id_uses_rs),
      .id_uses_rt                       (id_uses_rt),
      .ex_issue_valid                   (ex_issue_valid),
      .ex_issue_rd                      (ex_issue_rd),
      .ex_issue_lat                     (ex_issue_lat),
      .pridictor_wrong                  (pridictor_wrong),
      .if_id_pc_write                   (if_id_pc_write),
      .if_id_write_from_hazard_detector (if_id_write_from_hazard_detector),
`ifdef HAZARD_STALL_STATS_EN
      .stall_count                      (stall_count),
`endif
      .id_mux_load_use                  (id_mux_load_use)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check combinational outputs, advance model at posedge.
   task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic iv,
                       input logic [4:0] rd, input logic [2:0] lat, input logic pw);
      bit live, prs, prt, haz;
      rst = r; if_id_rs = rs; if_id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      ex_issue_valid = iv; ex_issue_rd = rd; ex_issue_lat = lat; pridictor_wrong = pw;
      if (r) foreach (m_rem[i]) m_rem[i] = 0;
      #1;
      live = iv && rd != 0 && lat != 0;
      prs  = (live && rd == rs) || (rs != 0 && m_rem[rs] > 0);
      prt  = (live && rd == rt) || (rt != 0 && m_rem[rt] > 0);
      haz  = (urs && prs) || (urt && prt);
      check("pc_write",   if_id_pc_write,                   !(haz && !pw));
      check("ifid_write", if_id_write_from_hazard_detector, !(haz || pw));
      check("mux",        id_mux_load_use,                  !(haz || pw));
      last_pc = if_id_pc_write; last_w = if_id_write_from_hazard_detector; last_m = id_mux_load_use;
`ifdef HAZARD_STALL_STATS_EN
      if (r) m_stats = 0;
      checks++;
      assert (stall_count === 32'(m_stats)) else begin
         errors++;
         $error("FAIL stall_count: observed %0d expected %0d", stall_count, m_stats);
      end
`endif
      @(posedge clk);
      if (!r) begin
         for (int i = 1; i < 32; i++) begin
            if (live && i == rd) m_rem[i] = int'(lat) - 1;
            else if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
         end
`ifdef HAZARD_STALL_STATS_EN
         if (haz && !pw && m_stats < 64'hFFFF_FFFF) m_stats++;
`endif
      end
      @(negedge clk);
   endtask

   initial begin
      int stalls;
      foreach (m_rem[i]) m_rem[i] = 0;
      @(negedge clk);
      // Reset state: nothing pending
      step(1, 0, 0, 1, 1, 0, 0, 0, 0);
      check("rst_pc", last_pc, 1'b1);
      check("rst_w",  last_w,  1'b1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Test 1: load-use r8 lat=1 -> one stall cycle
      step(0, 8, 0, 1, 0, 1, 8, 1, 0);
      check("t1_stall_m", last_m, 1'b0);
      check("t1_stall_pc", last_pc, 1'b0);
      step(0, 8, 0, 1, 0, 0, 0, 0, 0);
      check("t1_release", last_m, 1'b1);

      // Test 2: r9 lat=3 consumer on rt -> exactly 3 stall cycles
      stalls = 0;
      step(0, 0, 9, 0, 1, 1, 9, 3, 0);
      if (!last_w) stalls++;
      for (int k = 0; k < 8 && !last_w; k++) begin
         step(0, 0, 9, 0, 1, 0, 0, 0, 0);
         if (!last_w) stalls++;
      end
      check("t2_three_stalls", stalls == 3, 1'b1);

      // Test 3: rd=0 issue never stalls a reader of r0
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 1, 1, (k == 0), 0, 3, 0);
         check("t3_no_stall", last_m, 1'b1);
      end

      // Test 4: stall and mispredict together -> redirect wins on PC
      step(0, 0, 0, 0, 0, 1, 4, 3, 0);
      step(0, 4, 0, 1, 0, 0, 0, 0, 1);
      check("t4_pc", last_pc, 1'b1);
      check("t4_w",  last_w,  1'b0);
      check("t4_m",  last_m,  1'b0);

      // Test 5: reset mid-countdown clears r5
      step(0, 0, 0, 0, 0, 1, 5, 3, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 5, 0, 1, 0, 0, 0, 0, 0);
      check("t5_no_stall", last_m, 1'b1);

      // Test 6: WAW r6 lat=3 then lat=1 -> stall ends one cycle after second issue
      step(0, 0, 0, 0, 0, 1, 6, 3, 0);
      step(0, 6, 0, 1, 0, 1, 6, 1, 0);
      check("t6_stall", last_m, 1'b0);
      step(0, 6, 0, 1, 0, 0, 0, 0, 0);
      check("t6_release", last_m, 1'b1);

      // Randomized traffic over a narrow register range to provoke hazards
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 49) == 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom_range(0, 7)), 3'($urandom),
              ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
